cfg_reg_arbiter: RTL and testbench

Two-requester, round-robin arbiter that shares the single-ported configuration register file (8 × 16-bit registers, 3-bit address, `write`/`address`/`data_in`/`data_out`) between a host port (m0) and a built-in self-test port (m1). It accepts one access at a time, drives the register-file command lines from registered outputs, and returns read data with a valid pulse. A per-port lock gives a port exclusive back-to-back access for multi-register sequences. The block sits between the requesters and `config_reg`; the register file's own active-high `reset` is not driven by this block.

---
 rtl/cfg_reg_arbiter_if.sv | 49 ++++
 rtl/cfg_reg_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_cfg_reg_arbiter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cfg_reg_arbiter_if.sv
// Bus bundle between the two requesters (host m0, self-test m1), the arbiter
// and the single-ported configuration register file.
interface cfg_reg_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_lock;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_lock;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;

    logic              cfg_write;
    logic [ADDR_W-1:0] cfg_address;
    logic [DATA_W-1:0] cfg_data_in;
    logic [DATA_W-1:0] cfg_data_out;

    // Environment side: both requesters plus the register file read port.
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  cfg_write, cfg_address, cfg_data_in,
        output cfg_data_out
    );

    // Arbiter side.
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        output m1_gnt, m1_rvalid, m1_rdata,
        output cfg_write, cfg_address, cfg_data_in,
        input  cfg_data_out
    );
endinterface

// File: rtl/cfg_reg_arbiter.sv
// Round-robin arbiter with per-port lock sharing the configuration register
// file between the host (m0) and self-test (m1) ports; one access per 3 cycles.

// Protocol checker: grant/valid pulses are exclusive and writes only occur on a grant.
module cfg_reg_arbiter_chk (
    input logic clk,
    input logic reset,
    input logic m0_gnt,
    input logic m1_gnt,
    input logic m0_rvalid,
    input logic m1_rvalid,
    input logic cfg_write
);
    a_gnt_onehot: assert property (@(posedge clk) disable iff (!reset)
        !(m0_gnt && m1_gnt));
    a_rvalid_onehot: assert property (@(posedge clk) disable iff (!reset)
        !(m0_rvalid && m1_rvalid));
    a_write_on_gnt: assert property (@(posedge clk) disable iff (!reset)
        cfg_write |-> (m0_gnt || m1_gnt));
    a_gnt_not_with_rvalid: assert property (@(posedge clk) disable iff (!reset)
        !((m0_gnt || m1_gnt) && (m0_rvalid || m1_rvalid)));
    a_m0_gnt_pulse: assert property (@(posedge clk) disable iff (!reset)
        m0_gnt |=> !m0_gnt);
    a_m1_gnt_pulse: assert property (@(posedge clk) disable iff (!reset)
        m1_gnt |=> !m1_gnt);
endmodule

module cfg_reg_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input logic               clk,
    input logic               reset,
    cfg_reg_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t            state_r, state_s;
    // Port identifiers: 1'b0 = m0, 1'b1 = m1.
    logic              last_r, last_s;
    logic              owner_r, owner_s;
    logic              rd_r, rd_s;

    logic              cfg_write_r, cfg_write_s;
    logic [ADDR_W-1:0] cfg_address_r, cfg_address_s;
    logic [DATA_W-1:0] cfg_data_in_r, cfg_data_in_s;
    logic              m0_gnt_r, m0_gnt_s;
    logic              m1_gnt_r, m1_gnt_s;
    logic              m0_rvalid_r, m0_rvalid_s;
    logic              m1_rvalid_r, m1_rvalid_s;
    logic [DATA_W-1:0] m0_rdata_r, m0_rdata_s;
    logic [DATA_W-1:0] m1_rdata_r, m1_rdata_s;

    logic              any_req_s;
    logic              last_req_s;
    logic              last_lock_s;
    logic              win_s;
    logic              win_we_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic [DATA_W-1:0] win_wdata_s;

    // Winner selection: locked previous owner, else alternate on contention, else sole requester.
    always_comb begin
        any_req_s   = bus.m0_req | bus.m1_req;
        last_req_s  = last_r ? bus.m1_req  : bus.m0_req;
        last_lock_s = last_r ? bus.m1_lock : bus.m0_lock;
        win_s       = 1'b0;
        if (last_req_s && last_lock_s) begin
            win_s = last_r;
        end else if (bus.m0_req && bus.m1_req) begin
            win_s = ~last_r;
        end else if (bus.m0_req) begin
            win_s = 1'b0;
        end else begin
            win_s = 1'b1;
        end
        win_we_s    = win_s ? bus.m1_we    : bus.m0_we;
        win_addr_s  = win_s ? bus.m1_addr  : bus.m0_addr;
        win_wdata_s = win_s ? bus.m1_wdata : bus.m0_wdata;
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_s       = state_r;
        last_s        = last_r;
        owner_s       = owner_r;
        rd_s          = rd_r;
        cfg_write_s   = 1'b0;
        cfg_address_s = cfg_address_r;
        cfg_data_in_s = cfg_data_in_r;
        m0_gnt_s      = 1'b0;
        m1_gnt_s      = 1'b0;
        m0_rvalid_s   = 1'b0;
        m1_rvalid_s   = 1'b0;
        m0_rdata_s    = m0_rdata_r;
        m1_rdata_s    = m1_rdata_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_s       = ST_ACCESS;
                    owner_s       = win_s;
                    rd_s          = ~win_we_s;
                    cfg_write_s   = win_we_s;
                    cfg_address_s = win_addr_s;
                    cfg_data_in_s = win_wdata_s;
                    m0_gnt_s      = ~win_s;
                    m1_gnt_s      = win_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                state_s = ST_DONE;
                // cfg_data_out is a combinational read of cfg_address, stable all of ACCESS.
                if (rd_r && owner_r) begin
                    m1_rdata_s  = bus.cfg_data_out;
                    m1_rvalid_s = 1'b1;
                end else if (rd_r) begin
                    m0_rdata_s  = bus.cfg_data_out;
                    m0_rvalid_s = 1'b1;
                end else begin
                    m0_rvalid_s = 1'b0;
                    m1_rvalid_s = 1'b0;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                last_s  = owner_r;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Arbitration history, transaction context and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_r        <= 1'b1;
            owner_r       <= 1'b0;
            rd_r          <= 1'b0;
            cfg_write_r   <= 1'b0;
            cfg_address_r <= {ADDR_W{1'b0}};
            cfg_data_in_r <= {DATA_W{1'b0}};
            m0_gnt_r      <= 1'b0;
            m1_gnt_r      <= 1'b0;
            m0_rvalid_r   <= 1'b0;
            m1_rvalid_r   <= 1'b0;
            m0_rdata_r    <= {DATA_W{1'b0}};
            m1_rdata_r    <= {DATA_W{1'b0}};
        end else begin
            last_r        <= last_s;
            owner_r       <= owner_s;
            rd_r          <= rd_s;
            cfg_write_r   <= cfg_write_s;
            cfg_address_r <= cfg_address_s;
            cfg_data_in_r <= cfg_data_in_s;
            m0_gnt_r      <= m0_gnt_s;
            m1_gnt_r      <= m1_gnt_s;
            m0_rvalid_r   <= m0_rvalid_s;
            m1_rvalid_r   <= m1_rvalid_s;
            m0_rdata_r    <= m0_rdata_s;
            m1_rdata_r    <= m1_rdata_s;
        end
    end

    assign bus.cfg_write   = cfg_write_r;
    assign bus.cfg_address = cfg_address_r;
    assign bus.cfg_data_in = cfg_data_in_r;
    assign bus.m0_gnt      = m0_gnt_r;
    assign bus.m1_gnt      = m1_gnt_r;
    assign bus.m0_rvalid   = m0_rvalid_r;
    assign bus.m1_rvalid   = m1_rvalid_r;
    assign bus.m0_rdata    = m0_rdata_r;
    assign bus.m1_rdata    = m1_rdata_r;

    cfg_reg_arbiter_chk u_chk (
        .clk       (clk),
        .reset     (reset),
        .m0_gnt    (m0_gnt_r),
        .m1_gnt    (m1_gnt_r),
        .m0_rvalid (m0_rvalid_r),
        .m1_rvalid (m1_rvalid_r),
        .cfg_write (cfg_write_r)
    );
endmodule

// File: tb/tb_cfg_reg_arbiter.sv
// Directed bench for cfg_reg_arbiter with a behavioural 8x16 register file
// whose own reset loads 0xFFFF into every register.
module tb_cfg_reg_arbiter;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;

    logic clk = 1'b0;
    logic reset;
    logic rf_reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [DATA_W-1:0] rf [8];

    cfg_reg_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    cfg_reg_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.cfg_data_out = rf[bus.cfg_address];

    always @(posedge clk or posedge rf_reset) begin
        if (rf_reset) begin
            for (int i = 0; i < 8; i++) rf[i] <= 16'hFFFF;
        end else if (bus.cfg_write) begin
            rf[bus.cfg_address] <= bus.cfg_data_in;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = 3'd0; bus.m0_wdata = 16'h0000; bus.m0_lock = 1'b0;
        bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = 3'd0; bus.m1_wdata = 16'h0000; bus.m1_lock = 1'b0;
    endtask

    // Stimulus-only: one complete transaction on a single port, no checking.
    task automatic run_txn(input bit port, input bit we, input logic [2:0] addr, input logic [15:0] data);
        if (port) begin
            bus.m1_req = 1'b1; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = data;
        end else begin
            bus.m0_req = 1'b1; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = data;
        end
        step();
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rf_reset = 1'b1;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1;
        rf_reset = 1'b0;
        n_checks++;
        if ({bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.cfg_write} !== 5'b00000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b required 00000", {bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.cfg_write});
        end
        n_checks++;
        if ({bus.m0_rdata, bus.m1_rdata} !== 32'h0000_0000) begin
            n_fail++; $display("FAIL reset_rdata: got %h %h required 0000 0000", bus.m0_rdata, bus.m1_rdata);
        end
        n_checks++;
        if ({bus.cfg_address, bus.cfg_data_in} !== 19'h00000) begin
            n_fail++; $display("FAIL reset_cfg: got addr %h data %h required 0 0000", bus.cfg_address, bus.cfg_data_in);
        end
        reset = 1'b1;
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 3'd0;
        step();
        n_checks++;
        if ({bus.m0_gnt, bus.m1_gnt, bus.cfg_write} !== 3'b100) begin
            n_fail++; $display("FAIL first_gnt: got gnt0/gnt1/wr %b required 100", {bus.m0_gnt, bus.m1_gnt, bus.cfg_write});
        end
        bus.m0_req = 1'b0;
        step();
        n_checks++;
        if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== 16'hFFFF) begin
            n_fail++; $display("FAIL first_read: got rvalid %b rdata %h required 1 ffff", bus.m0_rvalid, bus.m0_rdata);
        end
        step();
        n_checks++;
        if (bus.m0_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL first_rvalid_pulse: got %b required 0", bus.m0_rvalid);
        end
    endtask

    task automatic test_write_read();
        bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 3'd4; bus.m0_wdata = 16'h5432;
        step();
        n_checks++;
        if ({bus.m0_gnt, bus.cfg_write} !== 2'b11 || bus.cfg_address !== 3'd4 || bus.cfg_data_in !== 16'h5432) begin
            n_fail++; $display("FAIL wr_access: got gnt %b wr %b addr %h data %h required 1 1 4 5432", bus.m0_gnt, bus.cfg_write, bus.cfg_address, bus.cfg_data_in);
        end
        bus.m0_req = 1'b0;
        step();
        n_checks++;
        if (bus.cfg_write !== 1'b0 || bus.m0_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL wr_done: got wr %b rvalid %b required 0 0", bus.cfg_write, bus.m0_rvalid);
        end
        step();
        n_checks++;
        if (bus.cfg_address !== 3'd4) begin
            n_fail++; $display("FAIL addr_hold: got %h required 4", bus.cfg_address);
        end
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 3'd4;
        step();
        n_checks++;
        if (bus.m0_gnt !== 1'b1 || bus.cfg_write !== 1'b0) begin
            n_fail++; $display("FAIL rd_gnt: got gnt %b wr %b required 1 0", bus.m0_gnt, bus.cfg_write);
        end
        bus.m0_req = 1'b0;
        step();
        n_checks++;
        if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== 16'h5432) begin
            n_fail++; $display("FAIL rd_data: got rvalid %b rdata %h required 1 5432", bus.m0_rvalid, bus.m0_rdata);
        end
        step();
    endtask

    task automatic test_contention();
        logic        exp_m1;
        logic [15:0] exp_data;
        run_txn(1'b0, 1'b1, 3'd1, 16'h1111);
        run_txn(1'b1, 1'b1, 3'd2, 16'h2222);
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 3'd1;
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 3'd2;
        for (int k = 0; k < 4; k++) begin
            exp_m1   = (k % 2 == 1);
            exp_data = exp_m1 ? 16'h2222 : 16'h1111;
            step();
            n_checks++;
            if ({bus.m0_gnt, bus.m1_gnt} !== {~exp_m1, exp_m1}) begin
                n_fail++; $display("FAIL cont_gnt%0d: got gnt0/gnt1 %b%b required %b%b", k, bus.m0_gnt, bus.m1_gnt, ~exp_m1, exp_m1);
            end
            if (k == 3) begin
                bus.m0_req = 1'b0;
                bus.m1_req = 1'b0;
            end
            step();
            n_checks++;
            if ({bus.m0_rvalid, bus.m1_rvalid} !== {~exp_m1, exp_m1} || (exp_m1 ? bus.m1_rdata : bus.m0_rdata) !== exp_data) begin
                n_fail++; $display("FAIL cont_rd%0d: got rvalid %b%b rdata %h/%h required %b%b %h", k, bus.m0_rvalid, bus.m1_rvalid, bus.m0_rdata, bus.m1_rdata, ~exp_m1, exp_m1, exp_data);
            end
            step();
            n_checks++;
            if ({bus.m0_gnt, bus.m1_gnt} !== 2'b00) begin
                n_fail++; $display("FAIL cont_gap%0d: got gnt0/gnt1 %b%b required 00", k, bus.m0_gnt, bus.m1_gnt);
            end
        end
    endtask

    task automatic test_lock();
        logic [15:0] lv [3];
        logic [2:0]  ea;
        lv[0] = 16'h0000; lv[1] = 16'hFFFF; lv[2] = 16'hAAAA;
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 3'd4;
        bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_lock = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ea = 3'(5 + k);
            bus.m1_addr  = ea;
            bus.m1_wdata = lv[k];
            step();
            n_checks++;
            if ({bus.m0_gnt, bus.m1_gnt} !== 2'b01 || bus.cfg_address !== ea || bus.cfg_data_in !== lv[k]) begin
                n_fail++; $display("FAIL lock_gnt%0d: got gnt %b%b addr %h data %h required 01 %h %h", k, bus.m0_gnt, bus.m1_gnt, bus.cfg_address, bus.cfg_data_in, ea, lv[k]);
            end
            if (k == 2) begin
                bus.m1_req  = 1'b0;
                bus.m1_lock = 1'b0;
            end
            step();
            step();
        end
        step();
        n_checks++;
        if ({bus.m0_gnt, bus.m1_gnt} !== 2'b10) begin
            n_fail++; $display("FAIL lock_release: got gnt0/gnt1 %b%b required 10", bus.m0_gnt, bus.m1_gnt);
        end
        bus.m0_req = 1'b0;
        step();
        n_checks++;
        if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== 16'h5432) begin
            n_fail++; $display("FAIL lock_m0_read: got rvalid %b rdata %h required 1 5432", bus.m0_rvalid, bus.m0_rdata);
        end
        step();
        n_checks++;
        if ({rf[5], rf[6], rf[7]} !== 48'h0000_FFFF_AAAA) begin
            n_fail++; $display("FAIL lock_regs: got %h %h %h required 0000 ffff aaaa", rf[5], rf[6], rf[7]);
        end
    endtask

    task automatic test_write_only();
        bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 3'd3; bus.m1_wdata = 16'hBEEF;
        step();
        n_checks++;
        if (bus.m1_gnt !== 1'b1 || bus.cfg_write !== 1'b1) begin
            n_fail++; $display("FAIL wo_gnt: got gnt %b wr %b required 1 1", bus.m1_gnt, bus.cfg_write);
        end
        bus.m1_req = 1'b0;
        step();
        n_checks++;
        if ({bus.m0_rvalid, bus.m1_rvalid} !== 2'b00 || bus.m1_rdata !== 16'h2222) begin
            n_fail++; $display("FAIL wo_no_rvalid: got rvalid %b%b rdata %h required 00 2222", bus.m0_rvalid, bus.m1_rvalid, bus.m1_rdata);
        end
        step();
        n_checks++;
        if (bus.m1_rdata !== 16'h2222 || rf[3] !== 16'hBEEF) begin
            n_fail++; $display("FAIL wo_hold: got rdata %h reg3 %h required 2222 beef", bus.m1_rdata, rf[3]);
        end
    endtask

    task automatic test_reset_access();
        bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 3'd0; bus.m0_wdata = 16'h1234;
        step();
        n_checks++;
        if (bus.cfg_write !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre: got wr %b required 1", bus.cfg_write);
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({bus.cfg_write, bus.m0_gnt} !== 2'b00) begin
            n_fail++; $display("FAIL rst_async: got wr/gnt %b required 00", {bus.cfg_write, bus.m0_gnt});
        end
        bus.m0_req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            n_checks++;
            if ({bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.cfg_write} !== 5'b00000) begin
                n_fail++; $display("FAIL rst_quiet%0d: got %b required 00000", k, {bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.cfg_write});
            end
        end
        n_checks++;
        if (rf[0] !== 16'hFFFF) begin
            n_fail++; $display("FAIL rst_no_write: got reg0 %h required ffff", rf[0]);
        end
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 3'd0;
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 3'd3;
        step();
        n_checks++;
        if ({bus.m0_gnt, bus.m1_gnt} !== 2'b10) begin
            n_fail++; $display("FAIL rst_idle_last: got gnt0/gnt1 %b%b required 10", bus.m0_gnt, bus.m1_gnt);
        end
        bus.m0_req = 1'b0;
        step();
        n_checks++;
        if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== 16'hFFFF) begin
            n_fail++; $display("FAIL rst_m0_read: got rvalid %b rdata %h required 1 ffff", bus.m0_rvalid, bus.m0_rdata);
        end
        step();
        step();
        n_checks++;
        if (bus.m1_gnt !== 1'b1) begin
            n_fail++; $display("FAIL rst_m1_gnt: got %b required 1", bus.m1_gnt);
        end
        bus.m1_req = 1'b0;
        step();
        n_checks++;
        if (bus.m1_rvalid !== 1'b1 || bus.m1_rdata !== 16'hBEEF) begin
            n_fail++; $display("FAIL rst_m1_read: got rvalid %b rdata %h required 1 beef", bus.m1_rvalid, bus.m1_rdata);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_contention();
        test_lock();
        test_write_only();
        test_reset_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
